// File: rtl/regfile_bist_ctrl_if.sv
// Regfile-side port bundle of the BIST controller: write port, two read ports and regfile reset.
// The controller is the master; read data is combinational from the regfile.
interface regfile_bist_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rf_reset;
  logic              rf_writeEn;
  logic [ADDR_W-1:0] rf_writeReg;
  logic [DATA_W-1:0] rf_writeData;
  logic [ADDR_W-1:0] rf_readRegA;
  logic [ADDR_W-1:0] rf_readRegB;
  logic [DATA_W-1:0] rf_readDataA;
  logic [DATA_W-1:0] rf_readDataB;

  modport master (
    output rf_reset, rf_writeEn, rf_writeReg, rf_writeData, rf_readRegA, rf_readRegB,
    input  rf_readDataA, rf_readDataB
  );

  modport slave (
    input  rf_reset, rf_writeEn, rf_writeReg, rf_writeData, rf_readRegA, rf_readRegB,
    output rf_readDataA, rf_readDataB
  );
endinterface

// File: rtl/regfile_bist_ctrl.sv
// Register-file BIST: clear, write/readback every register, clear again, confirm zero.
// Start-to-done is 2+3*NUM_REGS+2+2*NUM_REGS cycles; start is ignored while a run is in progress.
module regfile_bist_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                NUM_REGS = 32,
  parameter logic [DATA_W-1:0] PATTERN  = 32'h0000DEAD,
  parameter int                ERR_W    = 8
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                start,
  regfile_bist_ctrl_if.master rf,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    error_count,
  output logic [ADDR_W-1:0]   first_fail_reg
);

  typedef enum logic [3:0] {IDLE, CLR1, WR, RD, CMP, CLR2, RD0, CMP0, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, stateNext;
  logic [ADDR_W-1:0] idx, idxNext;
  logic              clrCnt, clrCntNext;
  logic [ERR_W-1:0]  errNext;
  logic [ADDR_W-1:0] firstFailNext;
  logic              passNext;
  logic [DATA_W-1:0] expData;
  logic              mismatchA, mismatchB;
  logic [ERR_W:0]    errSum;

  logic              rfResetNext, writeEnNext, busyNext, doneNext;
  logic [ADDR_W-1:0] writeRegNext, readRegNext;
  logic [DATA_W-1:0] writeDataNext;

  always_comb begin
    stateNext     = state;
    idxNext       = idx;
    clrCntNext    = clrCnt;
    errNext       = error_count;
    firstFailNext = first_fail_reg;
    passNext      = pass;
    expData       = '0;
    mismatchA     = 1'b0;
    mismatchB     = 1'b0;

    // Register 0 is hard-wired to zero, so its readback expectation is zero in both phases.
    if (state == CMP && idx != '0) expData = PATTERN ^ DATA_W'(idx);
    if (state == CMP || state == CMP0) begin
      mismatchA = (rf.rf_readDataA !== expData);
      mismatchB = (rf.rf_readDataB !== expData);
    end

    errSum = {1'b0, error_count} + {{ERR_W{1'b0}}, mismatchA} + {{ERR_W{1'b0}}, mismatchB};
    if (mismatchA || mismatchB) begin
      errNext = (errSum > {1'b0, {ERR_W{1'b1}}}) ? {ERR_W{1'b1}} : errSum[ERR_W-1:0];
      if (error_count == '0) firstFailNext = idx;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext     = CLR1;
          idxNext       = '0;
          clrCntNext    = 1'b0;
          errNext       = '0;
          firstFailNext = '0;
          passNext      = 1'b0;
        end
      end
      CLR1, CLR2: begin
        clrCntNext = ~clrCnt;
        if (clrCnt) stateNext = (state == CLR1) ? WR : RD0;
      end
      WR:  stateNext = RD;
      RD:  stateNext = CMP;
      CMP: begin
        if (idx == LAST_IDX) begin
          stateNext = CLR2;
          idxNext   = '0;
        end else begin
          stateNext = WR;
          idxNext   = idx + ADDR_W'(1);
        end
      end
      RD0: stateNext = CMP0;
      CMP0: begin
        if (idx == LAST_IDX) begin
          stateNext = DONE;
          passNext  = (errNext == '0);
        end else begin
          stateNext = RD0;
          idxNext   = idx + ADDR_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    rfResetNext   = (stateNext == CLR1) || (stateNext == CLR2);
    writeEnNext   = (stateNext == WR);
    writeRegNext  = writeEnNext ? idxNext : '0;
    writeDataNext = writeEnNext ? (PATTERN ^ DATA_W'(idxNext)) : '0;
    readRegNext   = (stateNext == RD || stateNext == CMP || stateNext == RD0 || stateNext == CMP0)
                    ? idxNext : '0;
    busyNext      = !(stateNext == IDLE || stateNext == DONE);
    doneNext      = (stateNext == DONE);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state           <= IDLE;
      idx             <= '0;
      clrCnt          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_fail_reg  <= '0;
      rf.rf_reset     <= 1'b0;
      rf.rf_writeEn   <= 1'b0;
      rf.rf_writeReg  <= '0;
      rf.rf_writeData <= '0;
      rf.rf_readRegA  <= '0;
      rf.rf_readRegB  <= '0;
    end else begin
      state           <= stateNext;
      idx             <= idxNext;
      clrCnt          <= clrCntNext;
      busy            <= busyNext;
      done            <= doneNext;
      pass            <= passNext;
      error_count     <= errNext;
      first_fail_reg  <= firstFailNext;
      rf.rf_reset     <= rfResetNext;
      rf.rf_writeEn   <= writeEnNext;
      rf.rf_writeReg  <= writeRegNext;
      rf.rf_writeData <= writeDataNext;
      rf.rf_readRegA  <= readRegNext;
      rf.rf_readRegB  <= readRegNext;
    end
  end

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Bench for regfile_bist_ctrl: a configurable faulty regfile model plus a second instance with
// a 1-bit error counter facing an always-wrong regfile.
module tb_regfile_bist_ctrl;

  localparam logic [31:0] PAT = 32'h0000DEAD;

  logic clock;
  logic ctrl_reset;
  logic start, start1;

  logic       busy, done, pass;
  logic [7:0] error_count;
  logic [4:0] first_fail_reg;
  logic       busy1, done1, pass1;
  logic [0:0] error_count1;
  logic [4:0] first_fail_reg1;

  int nPass  = 0;
  int nTotal = 0;

  // Fault knobs of the regfile model.
  int          faultReg   = -1;
  logic [31:0] faultMask  = '0;
  logic [1:0]  faultPorts = '0;
  bit          reg0Wr     = 1'b0;
  int          noRstReg   = -1;

  regfile_bist_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_bist_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

  regfile_bist_ctrl dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start), .rf(bus),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_reg(first_fail_reg)
  );

  regfile_bist_ctrl #(.ERR_W(1)) dut1 (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start1), .rf(bus1),
    .busy(busy1), .done(done1), .pass(pass1),
    .error_count(error_count1), .first_fail_reg(first_fail_reg1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] regs [32];
  logic [31:0] dA, dB;

  always @(posedge clock) begin
    if (bus.rf_reset) begin
      for (int i = 0; i < 32; i++) if (i != noRstReg) regs[i] <= '0;
    end else if (bus.rf_writeEn && (bus.rf_writeReg != 5'd0 || reg0Wr)) begin
      regs[bus.rf_writeReg] <= bus.rf_writeData;
    end
  end

  always_comb begin
    dA = regs[bus.rf_readRegA];
    dB = regs[bus.rf_readRegB];
    if (int'(bus.rf_readRegA) == faultReg && faultPorts[0]) dA = dA & ~faultMask;
    if (int'(bus.rf_readRegB) == faultReg && faultPorts[1]) dB = dB & ~faultMask;
  end

  assign bus.rf_readDataA  = dA;
  assign bus.rf_readDataB  = dB;
  assign bus1.rf_readDataA = 32'hFFFF_FFFF;
  assign bus1.rf_readDataB = 32'hFFFF_FFFF;

  // Expected {done, pass, error_count, first_fail_reg} from what a regfile with the current
  // fault knobs holds and returns in each phase.
  function automatic logic [14:0] refResult();
    int errs = 0;
    int ff   = -1;
    logic [31:0] stored, want, got;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 32; i++) begin
        want = (ph == 0 && i != 0) ? (PAT ^ i) : 32'd0;
        if (ph == 0) stored = (i == 0 && !reg0Wr) ? 32'd0 : (PAT ^ i);
        else         stored = (i == noRstReg) ? (PAT ^ i) : 32'd0;
        for (int p = 0; p < 2; p++) begin
          got = stored;
          if (i == faultReg && faultPorts[p]) got = got & ~faultMask;
          if (got !== want) begin
            errs++;
            if (ff < 0) ff = i;
          end
        end
      end
    end
    return {1'b1, errs == 0, (errs > 255) ? 8'hFF : 8'(errs), (ff < 0) ? 5'd0 : 5'(ff)};
  endfunction

  task automatic clearFaults();
    faultReg = -1; faultMask = '0; faultPorts = '0; reg0Wr = 1'b0; noRstReg = -1;
  endtask

  // Pulses start, then follows busy; optionally re-pulses start at busy cycle repulseAt.
  task automatic doRun(input int repulseAt, output int cyc, output int nWr, output int nRst,
                       output int badWr);
    cyc = 0; nWr = 0; nRst = 0; badWr = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (busy && cyc < 1000) begin
      cyc++;
      if (bus.rf_writeEn) begin
        nWr++;
        if (bus.rf_writeData !== (PAT ^ {27'd0, bus.rf_writeReg})) badWr++;
      end
      if (bus.rf_reset) nRst++;
      start = (cyc == repulseAt);
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1; start = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    nTotal++;
    if ({busy, done, pass, error_count, first_fail_reg} !== 16'd0)
      $display("FAIL reset_status got %h want 0000", {busy, done, pass, error_count, first_fail_reg});
    else nPass++;
    nTotal++;
    if ({bus.rf_reset, bus.rf_writeEn, bus.rf_writeReg, bus.rf_writeData, bus.rf_readRegA,
         bus.rf_readRegB} !== 49'd0)
      $display("FAIL reset_rfport got we=%b wreg=%0d wdat=%h rdA=%0d rdB=%0d rst=%b want all 0",
               bus.rf_writeEn, bus.rf_writeReg, bus.rf_writeData, bus.rf_readRegA,
               bus.rf_readRegB, bus.rf_reset);
    else nPass++;
    nTotal++;
    if ({busy1, done1, pass1, error_count1} !== 4'd0)
      $display("FAIL reset_dut1 got %b want 0000", {busy1, done1, pass1, error_count1});
    else nPass++;
  endtask

  task automatic test_scenario(input string name, input logic [14:0] expRes);
    int cyc, nWr, nRst, badWr;
    doRun(-1, cyc, nWr, nRst, badWr);
    nTotal++;
    if (cyc !== 164) $display("FAIL %s_busy_cycles got %0d want 164", name, cyc);
    else nPass++;
    nTotal++;
    if ({done, pass, error_count, first_fail_reg} !== expRes)
      $display("FAIL %s_result got done=%b pass=%b err=%0d ff=%0d want done=%b pass=%b err=%0d ff=%0d",
               name, done, pass, error_count, first_fail_reg,
               expRes[14], expRes[13], expRes[12:5], expRes[4:0]);
    else nPass++;
    nTotal++;
    if ({nWr, nRst, badWr} !== {32'd32, 32'd4, 32'd0})
      $display("FAIL %s_rf_traffic got writes=%0d resetCycles=%0d badData=%0d want 32/4/0",
               name, nWr, nRst, badWr);
    else nPass++;
  endtask

  task automatic test_faults();
    clearFaults();
    test_scenario("ideal", {1'b1, 1'b1, 8'd0, 5'd0});
    faultReg = 7; faultMask = 32'h8; faultPorts = 2'b11;
    test_scenario("stuck_r7b3", {1'b1, 1'b0, 8'd2, 5'd7});
    clearFaults(); reg0Wr = 1'b1;
    test_scenario("reg0_writable", {1'b1, 1'b0, 8'd2, 5'd0});
    clearFaults(); noRstReg = 5;
    test_scenario("no_reset_r5", {1'b1, 1'b0, 8'd2, 5'd5});
    clearFaults();
  endtask

  task automatic test_midrun_reset();
    clearFaults(); reg0Wr = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (39) begin @(posedge clock); #1; end
    nTotal++;
    if ({busy, error_count} !== {1'b1, 8'd2})
      $display("FAIL midrun_pre_reset got busy=%b err=%0d want busy=1 err=2", busy, error_count);
    else nPass++;
    ctrl_reset = 1'b1;
    @(posedge clock); #1;
    ctrl_reset = 1'b0;
    nTotal++;
    if ({busy, done, pass, error_count, first_fail_reg, bus.rf_reset, bus.rf_writeEn,
         bus.rf_readRegA, bus.rf_readRegB} !== 28'd0)
      $display("FAIL midrun_reset_outputs got busy=%b done=%b err=%0d rst=%b we=%b rdA=%0d want all 0",
               busy, done, error_count, bus.rf_reset, bus.rf_writeEn, bus.rf_readRegA);
    else nPass++;
    clearFaults();
    test_scenario("after_reset", {1'b1, 1'b1, 8'd0, 5'd0});
  endtask

  task automatic test_restart_ignored();
    int cyc, nWr, nRst, badWr, waitCyc;
    clearFaults(); faultReg = 12; faultMask = 32'h1; faultPorts = 2'b01;
    doRun(20, cyc, nWr, nRst, badWr);
    nTotal++;
    if (cyc !== 164) $display("FAIL restart_busy_cycles got %0d want 164", cyc);
    else nPass++;
    nTotal++;
    if ({done, pass, error_count, first_fail_reg} !== refResult())
      $display("FAIL restart_result got %h want %h", {done, pass, error_count, first_fail_reg},
               refResult());
    else nPass++;
    clearFaults();
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    waitCyc = 0;
    while (!done1 && waitCyc < 1000) begin
      waitCyc++;
      @(posedge clock); #1;
    end
    nTotal++;
    if (waitCyc !== 164) $display("FAIL errw1_busy_cycles got %0d want 164", waitCyc);
    else nPass++;
    nTotal++;
    if ({done1, busy1, pass1, error_count1, first_fail_reg1} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0})
      $display("FAIL errw1_result got done=%b busy=%b pass=%b err=%0d ff=%0d want 1/0/0/1/0",
               done1, busy1, pass1, error_count1, first_fail_reg1);
    else nPass++;
  endtask

  task automatic test_random();
    int cyc, nWr, nRst, badWr;
    logic [14:0] expRes;
    for (int n = 0; n < 6; n++) begin
      clearFaults();
      if ($urandom_range(0, 3) != 0) begin
        faultReg   = $urandom_range(0, 31);
        faultMask  = 32'h1 << $urandom_range(0, 31);
        faultPorts = 2'($urandom_range(1, 3));
      end
      reg0Wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) noRstReg = $urandom_range(1, 31);
      expRes = refResult();
      repeat ($urandom_range(0, 5)) begin @(posedge clock); #1; end
      doRun(-1, cyc, nWr, nRst, badWr);
      nTotal++;
      if (cyc !== 164) $display("FAIL rand%0d_busy_cycles got %0d want 164", n, cyc);
      else nPass++;
      nTotal++;
      if ({done, pass, error_count, first_fail_reg} !== expRes)
        $display("FAIL rand%0d_result got done=%b pass=%b err=%0d ff=%0d want done=%b pass=%b err=%0d ff=%0d",
                 n, done, pass, error_count, first_fail_reg,
                 expRes[14], expRes[13], expRes[12:5], expRes[4:0]);
      else nPass++;
    end
    clearFaults();
  endtask

  initial begin
    start = 1'b0; start1 = 1'b0; ctrl_reset = 1'b1;
    test_reset();
    test_faults();
    test_midrun_reset();
    test_restart_ignored();
    test_random();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
